// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Holds the request-sequencer state encoding and default counter widths.
package cpu_types_pkg;

  // Default widths for the request unit counters.
  localparam int unsigned RU_CNT_W_DEF   = 32;
  localparam int unsigned RU_STALL_W_DEF = 8;

  // Request sequencer states.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

endpackage : cpu_types_pkg

// File: rtl/request_unit_if.sv
// Port bundle for request_unit.
// ru: block-side view (controls and hits in, requests and status out).
// tb: bench-side view (drives controls and hits, observes requests and status).
interface request_unit_if #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STALL_W = 8
) (
  input logic CLK
);
  logic               RST;
  logic               ihit;
  logic               dhit;
  logic               dREN_in;
  logic               dWEN_in;
  logic               halt_in;
  logic               imemREN;
  logic               dmemREN;
  logic               dmemWEN;
  logic               pc_en;
  logic               halt;
  logic               protocol_err;
  logic [CNT_W-1:0]   retired;
  logic [STALL_W-1:0] stall_cnt;

  modport ru (
    input  CLK, RST, ihit, dhit, dREN_in, dWEN_in, halt_in,
    output imemREN, dmemREN, dmemWEN, pc_en, halt, protocol_err, retired, stall_cnt
  );

  modport tb (
    input  CLK, imemREN, dmemREN, dmemWEN, pc_en, halt, protocol_err, retired, stall_cnt,
    output RST, ihit, dhit, dREN_in, dWEN_in, halt_in
  );
endinterface : request_unit_if

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk/rst (async active-high), clr (priority over inc), inc, count.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise increment until all ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule : sat_counter

// File: rtl/request_unit.sv
// Memory request sequencer between the control unit and the memory arbiter.
// Inputs : CLK, RST (async active-high), ihit, dhit, dREN_in, dWEN_in, halt_in.
// Outputs: imemREN, pc_en (decoded from state/inputs); dmemREN, dmemWEN, halt,
//          protocol_err, retired, stall_cnt (registered).
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STALL_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               dREN_in,
  input  logic               dWEN_in,
  input  logic               halt_in,
  output logic               imemREN,
  output logic               dmemREN,
  output logic               dmemWEN,
  output logic               pc_en,
  output logic               halt,
  output logic               protocol_err,
  output logic [CNT_W-1:0]   retired,
  output logic [STALL_W-1:0] stall_cnt
);

  reqstate_t        state_q, state_d;
  logic             dmem_ren_q, dmem_ren_d;
  logic             dmem_wen_q, dmem_wen_d;
  logic             halt_q, halt_d;
  logic             perr_q, perr_d;
  logic [CNT_W-1:0] retired_q;
  logic             stall_clr;
  logic             stall_inc;

  // Next-state, request and commit decode.
  always_comb begin
    state_d    = state_q;
    dmem_ren_d = dmem_ren_q;
    dmem_wen_d = dmem_wen_q;
    halt_d     = halt_q;
    perr_d     = perr_q;
    imemREN    = 1'b0;
    pc_en      = 1'b0;
    stall_clr  = 1'b0;
    stall_inc  = 1'b0;

    unique case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (halt_in) begin
            // HALT beats any memory op decoded alongside it.
            state_d = HALTED;
            halt_d  = 1'b1;
          end else if (dREN_in || dWEN_in) begin
            // Load wins an illegal load+store; flag it stickily.
            state_d    = DATA;
            dmem_ren_d = dREN_in;
            dmem_wen_d = dWEN_in & ~dREN_in;
            stall_clr  = 1'b1;
            if (dREN_in && dWEN_in) begin
              perr_d = 1'b1;
            end
          end else begin
            pc_en = 1'b1;
          end
        end
      end

      DATA: begin
        // imemREN stays low so the data request owns the arbiter.
        if (dhit) begin
          pc_en      = 1'b1;
          dmem_ren_d = 1'b0;
          dmem_wen_d = 1'b0;
          state_d    = FETCH;
        end else begin
          stall_inc = 1'b1;
        end
      end

      HALTED: begin
        // Terminal until reset.
      end

      default: begin
        state_d    = FETCH;
        dmem_ren_d = 1'b0;
        dmem_wen_d = 1'b0;
      end
    endcase
  end

  // State and request registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= FETCH;
      dmem_ren_q <= 1'b0;
      dmem_wen_q <= 1'b0;
      halt_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dmem_ren_q <= dmem_ren_d;
      dmem_wen_q <= dmem_wen_d;
      halt_q     <= halt_d;
      perr_q     <= perr_d;
    end
  end

  // Retired-instruction counter, wraps.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      retired_q <= '0;
    end else if (pc_en) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Per-access data stall counter; frozen outside DATA.
  sat_counter #(
    .WIDTH (STALL_W)
  ) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (stall_clr),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  assign dmemREN      = dmem_ren_q;
  assign dmemWEN      = dmem_wen_q;
  assign halt         = halt_q;
  assign protocol_err = perr_q;
  assign retired      = retired_q;

endmodule : request_unit

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit (STALL_W=4) with a behavioural model.
module tb_request_unit;

  localparam int unsigned CNT_W     = 32;
  localparam int unsigned STALL_W   = 4;
  localparam int unsigned STALL_MAX = 15;

  logic CLK;
  int   checks;
  int   errors;

  // Behavioural model: a pending access is just "a load or a store is outstanding".
  bit          m_halted;
  bit          m_ld;
  bit          m_st;
  bit          m_perr;
  int unsigned m_stall;
  logic [31:0] m_retired;
  logic [31:0] ret_before;

  request_unit_if #(.CNT_W(CNT_W), .STALL_W(STALL_W)) rif (.CLK(CLK));

  request_unit #(
    .CNT_W   (CNT_W),
    .STALL_W (STALL_W)
  ) dut (
    .CLK          (CLK),
    .RST          (rif.RST),
    .ihit         (rif.ihit),
    .dhit         (rif.dhit),
    .dREN_in      (rif.dREN_in),
    .dWEN_in      (rif.dWEN_in),
    .halt_in      (rif.halt_in),
    .imemREN      (rif.imemREN),
    .dmemREN      (rif.dmemREN),
    .dmemWEN      (rif.dmemWEN),
    .pc_en        (rif.pc_en),
    .halt         (rif.halt),
    .protocol_err (rif.protocol_err),
    .retired      (rif.retired),
    .stall_cnt    (rif.stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_pc_en();
    if (m_halted) return 1'b0;
    if (m_ld || m_st) return rif.dhit;
    return rif.ihit && !rif.halt_in && !rif.dREN_in && !rif.dWEN_in;
  endfunction

  function automatic bit exp_imem();
    return !m_halted && !(m_ld || m_st);
  endfunction

  task automatic model_reset();
    m_halted  = 1'b0;
    m_ld      = 1'b0;
    m_st      = 1'b0;
    m_perr    = 1'b0;
    m_stall   = 0;
    m_retired = '0;
  endtask

  // Apply one clock edge's worth of architectural effect.
  task automatic model_edge();
    bit pe;
    pe = exp_pc_en();
    if (!m_halted) begin
      if (m_ld || m_st) begin
        if (rif.dhit) begin
          m_ld = 1'b0;
          m_st = 1'b0;
        end else if (m_stall < STALL_MAX) begin
          m_stall++;
        end
      end else if (rif.ihit) begin
        if (rif.halt_in) begin
          m_halted = 1'b1;
        end else if (rif.dREN_in || rif.dWEN_in) begin
          m_ld    = rif.dREN_in;
          m_st    = rif.dWEN_in && !rif.dREN_in;
          m_stall = 0;
          if (rif.dREN_in && rif.dWEN_in) m_perr = 1'b1;
        end
      end
    end
    if (pe) m_retired = m_retired + 32'd1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imemREN"},      32'(rif.imemREN),      32'(exp_imem()));
    chk({tag, ".pc_en"},        32'(rif.pc_en),        32'(exp_pc_en()));
    chk({tag, ".dmemREN"},      32'(rif.dmemREN),      32'(m_ld));
    chk({tag, ".dmemWEN"},      32'(rif.dmemWEN),      32'(m_st));
    chk({tag, ".halt"},         32'(rif.halt),         32'(m_halted));
    chk({tag, ".protocol_err"}, 32'(rif.protocol_err), 32'(m_perr));
    chk({tag, ".retired"},      rif.retired,           m_retired);
    chk({tag, ".stall_cnt"},    32'(rif.stall_cnt),    m_stall);
  endtask

  // Drive inputs at the falling edge, check mid-cycle, then take the rising edge.
  task automatic step(input bit ih, input bit dh, input bit rn, input bit wn,
                      input bit hl, input string tag);
    @(negedge CLK);
    rif.ihit    = ih;
    rif.dhit    = dh;
    rif.dREN_in = rn;
    rif.dWEN_in = wn;
    rif.halt_in = hl;
    #1;
    check_all(tag);
    @(posedge CLK);
    model_edge();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rif.RST     = 1'b1;
    rif.ihit    = 1'b0;
    rif.dhit    = 1'b0;
    rif.dREN_in = 1'b0;
    rif.dWEN_in = 1'b0;
    rif.halt_in = 1'b0;
    model_reset();

    // Reset values.
    @(negedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    rif.RST = 1'b0;

    // ALU stream: five back-to-back commits.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, "alu");
    #1;
    chk("alu.retired5", rif.retired, 32'd5);

    // Load with three wait cycles.
    ret_before = m_retired;
    step(1, 0, 1, 0, 0, "ld.issue");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "ld.wait");
    step(0, 1, 0, 0, 0, "ld.hit");
    #1;
    chk("ld.stall", 32'(rif.stall_cnt), 32'd3);
    chk("ld.retired", rif.retired, ret_before + 32'd1);

    // Store completing in its first DATA cycle.
    step(1, 0, 0, 1, 0, "st.issue");
    #1;
    chk("st.wen", 32'(rif.dmemWEN), 32'd1);
    step(0, 1, 0, 0, 0, "st.hit");
    #1;
    chk("st.wen_drop", 32'(rif.dmemWEN), 32'd0);
    chk("st.stall", 32'(rif.stall_cnt), 32'd0);

    // Stall saturation.
    step(1, 0, 1, 0, 0, "sat.issue");
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, "sat.wait");
    #1;
    chk("sat.max", 32'(rif.stall_cnt), 32'd15);
    step(0, 1, 0, 0, 0, "sat.hit");
    #1;
    chk("sat.freeze", 32'(rif.stall_cnt), 32'd15);
    step(1, 0, 0, 0, 0, "sat.fetch");

    // Illegal load+store: load wins, error is sticky.
    step(1, 0, 1, 1, 0, "ill.issue");
    #1;
    chk("ill.ren", 32'(rif.dmemREN), 32'd1);
    chk("ill.wen", 32'(rif.dmemWEN), 32'd0);
    chk("ill.perr", 32'(rif.protocol_err), 32'd1);
    step(0, 1, 0, 0, 0, "ill.hit");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "ill.after");
    #1;
    chk("ill.sticky", 32'(rif.protocol_err), 32'd1);

    // Randomized traffic, no halts.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), 1'b0, "rand");
    end

    // Asynchronous reset in the middle of a pending load.
    step(1, 0, 1, 0, 0, "rst.issue");
    @(negedge CLK);
    rif.ihit    = 1'b0;
    rif.dhit    = 1'b0;
    rif.dREN_in = 1'b0;
    rif.dWEN_in = 1'b0;
    chk("rst.pre_ren", 32'(rif.dmemREN), 32'd1);
    rif.RST = 1'b1;
    #1;
    model_reset();
    chk("rst.ren", 32'(rif.dmemREN), 32'd0);
    chk("rst.imem", 32'(rif.imemREN), 32'd1);
    chk("rst.retired", rif.retired, 32'd0);
    check_all("rst.async");
    @(negedge CLK);
    rif.RST = 1'b0;

    // Halt with a store decoded alongside: store never issues.
    step(1, 0, 0, 0, 0, "halt.alu");
    step(1, 0, 0, 1, 1, "halt.issue");
    ret_before = m_retired;
    for (int i = 0; i < 12; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "halted");
    end
    #1;
    chk("halt.flag", 32'(rif.halt), 32'd1);
    chk("halt.wen", 32'(rif.dmemWEN), 32'd0);
    chk("halt.retired", rif.retired, ret_before);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_request_unit
